// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store access controller.
// Turns MEM-stage load/store requests into single-word bus transactions, stalls the
// pipeline while one is in flight, formats load results and aborts on a bus timeout.
// Optional build macro: MISALIGN_TRAP_EN traps misaligned half/word accesses instead of
// issuing them at the naturally aligned address.
module mem_access_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        stallreq_mem,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        misalign_exc
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  // Counter value seen in the last REQ/WAIT cycle allowed before abort.
  localparam logic [7:0] LastCnt = 8'(MAX_WAIT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        bus_err_q;
  logic        misalign_q;

  logic        req_any;
  logic        misalign_c;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;

  // Extract and extend the addressed lane; funct3[1:0] of 10/11 always means word.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Request decode, misalignment detection and store lane replication.
  // Without the trap, half/word lanes ignore the low address bits, which forces
  // natural alignment.
  always_comb begin
    req_any = mem_re | mem_we;
`ifdef MISALIGN_TRAP_EN
    misalign_c = req_any && (((mem_funct3[1:0] == 2'b01) && mem_addr[0]) ||
                             (mem_funct3[1] && (mem_addr[1:0] != 2'b00)));
`else
    misalign_c = 1'b0;
`endif
    case (mem_funct3[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << mem_addr[1:0];
        wdata_c = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        wstrb_c = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_wdata[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = mem_wdata;
      end
    endcase
    // Loads never enable write lanes; a simultaneous re/we is a store.
    if (!mem_we) wstrb_c = 4'b0000;
  end

  // Transaction FSM with registered bus fields, result and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      misalign_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            if (misalign_c) begin
              state_q     <= StDone;
              misalign_q  <= 1'b1;
              load_data_q <= 32'd0;
            end else begin
              state_q <= StReq;
              cnt_q   <= 8'd0;
              we_q    <= mem_we;
              f3_q    <= mem_funct3;
              off_q   <= mem_addr[1:0];
              addr_q  <= {mem_addr[31:2], 2'b00};
              wdata_q <= wdata_c;
              wstrb_q <= wstrb_c;
            end
          end
        end
        StReq: begin
          if (dm_gnt && we_q) begin
            state_q <= StDone;
          end else if (dm_gnt && dm_rvalid) begin
            state_q      <= StDone;
            load_data_q  <= fmt_load(dm_rdata, f3_q, off_q);
            load_valid_q <= 1'b1;
          end else if (cnt_q == LastCnt) begin
            state_q     <= StDone;
            bus_err_q   <= 1'b1;
            load_data_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (dm_gnt) state_q <= StWait;
          end
        end
        StWait: begin
          if (dm_rvalid) begin
            state_q      <= StDone;
            load_data_q  <= fmt_load(dm_rdata, f3_q, off_q);
            load_valid_q <= 1'b1;
          end else if (cnt_q == LastCnt) begin
            state_q     <= StDone;
            bus_err_q   <= 1'b1;
            load_data_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall from the requesting IDLE cycle until DONE; never while a trap is taken.
  always_comb begin
    stallreq_mem = !rst && (((state_q == StIdle) && req_any && !misalign_c) ||
                            (state_q == StReq) || (state_q == StWait));
  end

  assign dm_req       = (state_q == StReq);
  assign dm_we        = we_q;
  assign dm_addr      = addr_q;
  assign dm_wstrb     = wstrb_q;
  assign dm_wdata     = wdata_q;
  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign bus_err      = bus_err_q;
  assign misalign_exc = misalign_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: bus handshakes driven step by step, completion
// pulses checked against a scoreboard of expected results.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [2:0]  mem_funct3 = 3'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_gnt = 1'b0;
  logic        dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = 32'd0;
  logic        stallreq_mem;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;
  logic        misalign_exc;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .stallreq_mem(stallreq_mem),
    .load_data(load_data), .load_valid(load_valid), .bus_err(bus_err),
    .misalign_exc(misalign_exc)
  );

  typedef struct {
    logic        lv;
    logic        be;
    logic        mx;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #2;
    if (!rst && (load_valid || bus_err || misalign_exc)) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=lv%0b/be%0b/mx%0b expected=no pulse",
               load_valid, bus_err, misalign_exc);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_load_valid", load_valid, e.lv);
        chk("sb_bus_err", bus_err, e.be);
        chk("sb_misalign", misalign_exc, e.mx);
        chk("sb_load_data", load_data, e.data);
      end
    end
  end

  // Load: gnt after gnt_dly REQ cycles, then wait_cyc WAIT cycles (rvalid in the last).
  task automatic load_txn(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input int gnt_dly, input int wait_cyc,
                          input logic [31:0] exp);
    int stalls;
    stalls = 0;
    @(negedge clk);
    mem_re = 1'b1; mem_we = 1'b0; mem_funct3 = f3; mem_addr = addr;
    mem_wdata = 32'hFFFF_FFFF;
    sb.push_back('{lv: 1'b1, be: 1'b0, mx: 1'b0, data: exp});
    #1 stalls += int'(stallreq_mem);
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk); dm_gnt = 1'b0; dm_rvalid = 1'b0;
      #1 chk({tag, "_req_hold"}, dm_req, 1);
      stalls += int'(stallreq_mem);
    end
    @(negedge clk);
    dm_gnt = 1'b1; dm_rvalid = (wait_cyc == 0);
    dm_rdata = (wait_cyc == 0) ? rdata : 32'h5555_AAAA;
    #1 chk({tag, "_dm_req"}, dm_req, 1);
    chk({tag, "_dm_we"}, dm_we, 0);
    chk({tag, "_dm_addr"}, dm_addr, {addr[31:2], 2'b00});
    chk({tag, "_dm_wstrb"}, dm_wstrb, 0);
    stalls += int'(stallreq_mem);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      dm_gnt = 1'b0; dm_rvalid = (i == wait_cyc - 1);
      dm_rdata = (i == wait_cyc - 1) ? rdata : 32'h5555_AAAA;
      #1 chk({tag, "_wait_no_req"}, dm_req, 0);
      stalls += int'(stallreq_mem);
    end
    @(negedge clk);
    mem_re = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0;
    #1 chk({tag, "_done_valid"}, load_valid, 1);
    chk({tag, "_done_stall"}, stallreq_mem, 0);
    chk({tag, "_stall_cycles"}, stalls, 2 + gnt_dly + wait_cyc);
    @(negedge clk);
    #1 chk({tag, "_valid_pulse"}, load_valid, 0);
  endtask

  // Store: bus fields must hold steady through every REQ cycle until gnt.
  task automatic store_txn(input string tag, input logic re, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_dly, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata);
    int stalls;
    stalls = 0;
    @(negedge clk);
    mem_re = re; mem_we = 1'b1; mem_funct3 = f3; mem_addr = addr; mem_wdata = wdata;
    #1 stalls += int'(stallreq_mem);
    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge clk); dm_gnt = (i == gnt_dly);
      #1 chk({tag, "_dm_req"}, dm_req, 1);
      chk({tag, "_dm_we"}, dm_we, 1);
      chk({tag, "_dm_addr"}, dm_addr, {addr[31:2], 2'b00});
      chk({tag, "_dm_wstrb"}, dm_wstrb, exp_strb);
      chk({tag, "_dm_wdata"}, dm_wdata, exp_wdata);
      stalls += int'(stallreq_mem);
    end
    @(negedge clk);
    mem_re = 1'b0; mem_we = 1'b0; dm_gnt = 1'b0;
    #1 chk({tag, "_done_stall"}, stallreq_mem, 0);
    chk({tag, "_no_load_valid"}, load_valid, 0);
    chk({tag, "_stall_cycles"}, stalls, 2 + gnt_dly);
  endtask

  initial begin
    int stalls;
    // Reset state.
    repeat (2) @(negedge clk);
    #1 chk("rst_dm_req", dm_req, 0);
    chk("rst_stall", stallreq_mem, 0);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_misalign", misalign_exc, 0);
    chk("rst_load_data", load_data, 0);
    rst = 1'b0;

    // Zero-wait word load, then sign/zero-extended lanes with WAIT cycles.
    load_txn("lw_fast", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
    load_txn("lb_103", 3'b000, 32'h0000_0103, 32'h8011_2233, 0, 3, 32'hFFFF_FF80);
    load_txn("lbu_103", 3'b100, 32'h0000_0103, 32'h8011_2233, 0, 3, 32'h0000_0080);
    load_txn("lb_101", 3'b000, 32'h0000_0101, 32'h8011_2233, 1, 1, 32'h0000_0022);
    load_txn("lh_102", 3'b001, 32'h0000_0102, 32'h8011_2233, 2, 0, 32'hFFFF_8011);
    load_txn("lhu_100", 3'b101, 32'h0000_0100, 32'h8011_2233, 0, 2, 32'h0000_2233);
    load_txn("ld_f3_111", 3'b111, 32'h0000_0108, 32'h8011_2233, 1, 1, 32'h8011_2233);

    // Stores, including re+we treated as a store.
    store_txn("sh_202", 1'b0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 2, 4'b1100,
              32'hABCD_ABCD);
    store_txn("sb_201", 1'b0, 3'b000, 32'h0000_0201, 32'h0000_005A, 0, 4'b0010,
              32'h5A5A_5A5A);
    store_txn("sw_204", 1'b0, 3'b010, 32'h0000_0204, 32'h1122_3344, 1, 4'b1111,
              32'h1122_3344);
    store_txn("rewe_203", 1'b1, 3'b000, 32'h0000_0203, 32'h0000_0077, 0, 4'b1000,
              32'h7777_7777);

    // Timeout: granted load that never returns data.
    @(negedge clk);
    mem_re = 1'b1; mem_we = 1'b0; mem_funct3 = 3'b010; mem_addr = 32'h0000_0300;
    sb.push_back('{lv: 1'b0, be: 1'b1, mx: 1'b0, data: 32'd0});
    #1 stalls = int'(stallreq_mem);
    @(negedge clk); dm_gnt = 1'b1;
    #1 stalls += int'(stallreq_mem);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); dm_gnt = 1'b0;
      #1 if (!stallreq_mem) break;
      stalls++;
    end
    chk("to_stall_cycles", stalls, 17);
    chk("to_bus_err", bus_err, 1);
    chk("to_load_valid", load_valid, 0);
    chk("to_load_data", load_data, 0);
    mem_re = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h1357_9BDF;
    @(negedge clk);
    #1 chk("to_late_rvalid_lv", load_valid, 0);
    chk("to_late_rvalid_stall", stallreq_mem, 0);
    chk("to_err_pulse", bus_err, 0);
    dm_rvalid = 1'b0;

    // Reset while in WAIT, with a concurrent rvalid that must be dropped.
    @(negedge clk);
    mem_re = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h0000_0400;
    @(negedge clk); dm_gnt = 1'b1;
    @(negedge clk); dm_gnt = 1'b0;
    #1 chk("rw_in_wait_req", dm_req, 0);
    chk("rw_in_wait_stall", stallreq_mem, 1);
    @(negedge clk); rst = 1'b1; mem_re = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hAAAA_5555;
    @(negedge clk); dm_rvalid = 1'b0;
    #1 chk("rw_dm_req", dm_req, 0);
    chk("rw_stall", stallreq_mem, 0);
    chk("rw_load_valid", load_valid, 0);
    chk("rw_bus_err", bus_err, 0);
    rst = 1'b0;
    store_txn("sw_after_rst", 1'b0, 3'b010, 32'h0000_0500, 32'hCAFE_0001, 0, 4'b1111,
              32'hCAFE_0001);

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load traps without touching the bus.
    @(negedge clk);
    mem_re = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h0000_0101;
    sb.push_back('{lv: 1'b0, be: 1'b0, mx: 1'b1, data: 32'd0});
    #1 chk("mx_idle_stall", stallreq_mem, 0);
    chk("mx_idle_req", dm_req, 0);
    @(negedge clk); mem_re = 1'b0;
    #1 chk("mx_done_exc", misalign_exc, 1);
    chk("mx_done_req", dm_req, 0);
    @(negedge clk);
    #1 chk("mx_after_req", dm_req, 0);
    chk("mx_exc_pulse", misalign_exc, 0);
`else
    // Misaligned word load is issued at the aligned address with no exception.
    load_txn("lw_unalign", 3'b010, 32'h0000_0101, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D);
    chk("ua_no_exc", misalign_exc, 0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 16: cycles allowed in REQ+WAIT before the transaction is abandoned; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_re  input  1  MEM-stage load request, held stable while stallreq_mem=1.
REQ-005 mem_we  input  1  MEM-stage store request, held stable while stallreq_mem=1.
REQ-006 mem_funct3  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 mem_addr  input  32  byte address.
REQ-008 mem_wdata  input  32  store data, low bits significant.
REQ-009 dm_req  output  1  bus request; dm_we/dm_addr/dm_wstrb/dm_wdata stable while dm_req=1 and dm_gnt=0.
REQ-010 dm_we  output  1  1 = write.
REQ-011 dm_addr  output  32  {mem_addr[31:2],2'b00}.
REQ-012 dm_wstrb  output  4  byte enables; 0000 on loads.
REQ-013 dm_wdata  output  32  lane-replicated store data.
REQ-014 dm_gnt  input  1  bus accepts request this cycle.
REQ-015 dm_rvalid  input  1  read data valid this cycle.
REQ-016 dm_rdata  input  32  read word.
REQ-017 stallreq_mem  output  1  MEM stall request to the pipeline stall controller.
REQ-018 load_data  output  32  formatted load result, valid when load_valid=1.
REQ-019 load_valid  output  1  one-cycle pulse, completed load.
REQ-020 bus_err  output  1  one-cycle pulse, timeout abort.
REQ-021 misalign_exc  output  1  one-cycle pulse, misaligned access (see Configuration).

Function
REQ-022 FSM states IDLE, REQ, WAIT, DONE; the block SHALL start no transaction from DONE.
REQ-023 IDLE with mem_re|mem_we -> REQ; stallreq_mem=1 combinationally in that same IDLE cycle and throughout REQ/WAIT; 0 in IDLE without request and in DONE.
REQ-024 mem_re=mem_we=1 SHALL be treated as a store.
REQ-025 REQ: dm_req=1; on dm_gnt store -> DONE; load with dm_rvalid same cycle -> DONE; load otherwise -> WAIT.
REQ-026 WAIT: dm_req=0; on dm_rvalid capture formatted data -> DONE.
REQ-027 DONE: load_valid=1 for loads, load_data held; next state IDLE; minimum latency request->DONE is 1 cycle (REQ entered cycle N, DONE cycle N+1... zero wait: stall 2 cycles total).
REQ-028 Wait counter clears on entering REQ, increments each REQ/WAIT cycle; on reaching MAX_WAIT -> DONE with bus_err=1, load_data=0, load_valid=0.
REQ-029 dm_rvalid in IDLE/DONE SHALL be ignored.
REQ-030 Store: SB wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH wstrb=0011<<{addr[1],0}, wdata={2{wdata[15:0]}}; SW 1111.
REQ-031 Load: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; funct3 011/110/111 SHALL be treated as word.

Reset
REQ-032 rst SHALL force IDLE, counter 0, dm_req=0, stallreq_mem=0, load_valid=0, bus_err=0, misalign_exc=0, load_data=0, including mid-transaction.

Configuration
REQ-033 Macro MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL issue no bus request, go IDLE->DONE with misalign_exc=1, load_data=0, stallreq_mem=0.
REQ-034 Macro undefined: misalign_exc tied 0; half/word accesses use addr forced to natural alignment.

Verification
REQ-035 LW 0x100, gnt+rvalid same cycle, rdata=0xDEADBEEF -> stallreq_mem 2 cycles, load_valid with load_data=0xDEADBEEF.
REQ-036 LB addr 0x103, rdata=0x80112233 after 3 WAIT cycles -> load_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-037 SH addr 0x202, wdata=0x1234ABCD, gnt delayed 2 cycles -> dm_wstrb=1100, dm_wdata=0xABCDABCD, stable until gnt.
REQ-038 Load, no rvalid, MAX_WAIT=16 -> bus_err pulse after 16 cycles, stallreq_mem drops, later rvalid ignored.
REQ-039 rst asserted in WAIT -> IDLE next cycle, dm_req=0, stallreq_mem=0.
REQ-040 MISALIGN_TRAP_EN, LW addr 0x101 -> misalign_exc=1, dm_req never asserted.
